// File: rtl/phase_a_issuer.sv
// phase_a initiator: folds MS-first digits through phase_a into a Size-bit residue; PA_WATCHDOG_EN adds a WAIT timeout.
// Latency: pa_en 2 cycles after a digit handshake; res_valid 1 cycle after the final pa_en_out.
// Backpressure: din_ready low while a reduction is in flight or a result is pending; res held until res_ready.
module phase_a_issuer #(
  parameter int Size       = 3072,
  parameter int radix      = 78,
  parameter int MAX_DIGITS = 64,
  localparam int CntW      = $clog2(MAX_DIGITS + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [radix-1:0]        din,
  input  logic                    din_valid,
  input  logic                    din_last,
  output logic                    din_ready,
  output logic [Size+radix:0]     pa_a,
  output logic                    pa_en,
  input  logic [Size-1:0]         pa_new_a,
  input  logic                    pa_en_out,
  output logic [Size-1:0]         res,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [CntW-1:0]         digit_cnt,
  output logic                    err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_LOAD,
    S_OUT
  } state_t;

  state_t           state;
  logic [Size-1:0]  acc;
  logic [radix-1:0] digit;
  logic             last;

`ifdef PA_WATCHDOG_EN
  logic [15:0]      wd_cnt;
  wire              wd_expired = (wd_cnt == 16'hFFFF) && !pa_en_out;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      acc       <= '0;
      digit     <= '0;
      last      <= 1'b0;
      pa_a      <= '0;
      pa_en     <= 1'b0;
      res       <= '0;
      res_valid <= 1'b0;
      digit_cnt <= '0;
      err       <= 1'b0;
      din_ready <= 1'b0;
`ifdef PA_WATCHDOG_EN
      wd_cnt    <= '0;
`endif
    end else begin
      pa_en <= 1'b0;
      // A result strobe with no reduction outstanding is a protocol violation.
      if (pa_en_out && state != S_WAIT)
        err <= 1'b1;
`ifdef PA_WATCHDOG_EN
      if (state == S_WAIT && !pa_en_out && !wd_expired)
        wd_cnt <= wd_cnt + 16'd1;
      else
        wd_cnt <= '0;
`endif
      case (state)
        S_IDLE: begin
          acc       <= '0;
          digit_cnt <= '0;
          din_ready <= 1'b1;
          if (din_valid && din_ready) begin
            digit     <= din;
            last      <= din_last;
            din_ready <= 1'b0;
            state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          pa_a  <= {1'b0, acc, digit};
          pa_en <= 1'b1;
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (pa_en_out) begin
            acc       <= pa_new_a;
            digit_cnt <= digit_cnt + CntW'(1);
            if (last) begin
              res       <= pa_new_a;
              res_valid <= 1'b1;
              state     <= S_OUT;
            end else begin
              din_ready <= 1'b1;
              state     <= S_LOAD;
            end
          end
`ifdef PA_WATCHDOG_EN
          else if (wd_expired) begin
            // Give up on phase_a and hand out the partial residue.
            err       <= 1'b1;
            res       <= acc;
            res_valid <= 1'b1;
            state     <= S_OUT;
          end
`endif
        end
        S_LOAD: begin
          din_ready <= 1'b1;
          if (din_valid && din_ready) begin
            din_ready <= 1'b0;
            if (digit_cnt == CntW'(MAX_DIGITS)) begin
              // Operand too long: drop the digit and close out with what we have.
              err       <= 1'b1;
              res       <= acc;
              res_valid <= 1'b1;
              state     <= S_OUT;
            end else begin
              digit <= din;
              last  <= din_last;
              state <= S_ISSUE;
            end
          end
        end
        S_OUT: begin
          if (res_valid && res_ready) begin
            res_valid <= 1'b0;
            acc       <= '0;
            digit_cnt <= '0;
            din_ready <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: begin
          state     <= S_IDLE;
          din_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_phase_a_issuer.sv
// Randomized bench for phase_a_issuer with a 14-cycle phase_a stub and a digit-folding reference model.
module tb_phase_a_issuer;
  localparam int Size       = 3072;
  localparam int RADIX      = 78;
  localparam int MAX_DIGITS = 64;
  localparam int CW         = $clog2(MAX_DIGITS + 1);
  localparam int AW         = Size + RADIX + 1;
  localparam int MAX_WAIT   = 1000;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [RADIX-1:0]  din = '0;
  logic              din_valid = 1'b0;
  logic              din_last = 1'b0;
  logic              din_ready;
  logic [AW-1:0]     pa_a;
  logic              pa_en;
  logic [Size-1:0]   pa_new_a = '0;
  logic              stub_eo = 1'b0;
  logic              spur_eo = 1'b0;
  logic              pa_en_out;
  logic [Size-1:0]   res;
  logic              res_valid;
  logic              res_ready = 1'b0;
  logic [CW-1:0]     digit_cnt;
  logic              err;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int eo_cyc = -100;

  logic [RADIX-1:0]  digs [0:MAX_DIGITS];
  logic [AW-1:0]     pa_log [$];

  assign pa_en_out = stub_eo | spur_eo;

  phase_a_issuer #(.Size(Size), .radix(RADIX), .MAX_DIGITS(MAX_DIGITS)) dut (
    .clk(clk), .rst_n(rst_n),
    .din(din), .din_valid(din_valid), .din_last(din_last), .din_ready(din_ready),
    .pa_a(pa_a), .pa_en(pa_en), .pa_new_a(pa_new_a), .pa_en_out(pa_en_out),
    .res(res), .res_valid(res_valid), .res_ready(res_ready),
    .digit_cnt(digit_cnt), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check_val(input string tag, input logic [AW-1:0] got, input logic [AW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (low 256 bits)", tag, got[255:0], exp[255:0]);
    end
  endtask

  // Reference: each reduction returns the low Size bits of (acc * 2^radix + digit).
  function automatic logic [Size-1:0] model_step(input logic [Size-1:0] acc, input logic [RADIX-1:0] d);
    return (acc << RADIX) | Size'(d);
  endfunction

  // phase_a stub plus pa_en pulse-shape monitor.
  bit stub_on = 1'b1;
  bit pend = 1'b0;
  int cd = 0;
  int hi_run = 0;
  int lo_run = 100;
  always @(negedge clk) begin
    stub_eo = 1'b0;
    if (!rst_n) pend = 1'b0;
    else if (pend) begin
      cd--;
      if (cd == 0) begin
        pend = 1'b0;
        stub_eo = 1'b1;
        eo_cyc = cyc;
      end
    end
    if (rst_n && pa_en) begin
      if (hi_run == 0) begin
        check_val("pa_en_gap", AW'(lo_run >= 2), AW'(1));
        pa_log.push_back(pa_a);
        if (stub_on) begin
          pend = 1'b1;
          cd = 14;
          pa_new_a = pa_a[Size-1:0];
        end
      end
      hi_run++;
      lo_run = 0;
    end else begin
      if (hi_run != 0) check_val("pa_en_width", AW'(hi_run), AW'(1));
      hi_run = 0;
      lo_run++;
    end
  end

  task automatic send_digit(input logic [RADIX-1:0] d, input bit last);
    int n;
    n = 0;
    din = d;
    din_last = last;
    din_valid = 1'b1;
    while (!din_ready && n < MAX_WAIT) begin
      @(negedge clk);
      n++;
    end
    if (n >= MAX_WAIT) check_val("din_ready_timeout", AW'(0), AW'(1));
    @(negedge clk);
    din_valid = 1'b0;
    din_last = 1'b0;
  endtask

  task automatic check_result(input int n, input bit exp_err, input bit chk_lat);
    logic [Size-1:0] acc;
    int t;
    acc = '0;
    t = 0;
    while (!res_valid && t < MAX_WAIT) begin
      @(negedge clk);
      t++;
    end
    check_val("res_valid", AW'(res_valid), AW'(1));
    if (chk_lat) check_val("res_latency", AW'(cyc - eo_cyc), AW'(1));
    for (int i = 0; i < n; i++) begin
      if (i < pa_log.size()) check_val("pa_a", pa_log[i], {1'b0, acc, digs[i]});
      acc = model_step(acc, digs[i]);
    end
    check_val("launches", AW'(pa_log.size()), AW'(n));
    check_val("res", AW'(res), AW'(acc));
    check_val("digit_cnt", AW'(digit_cnt), AW'(n));
    check_val("err", AW'(err), AW'(exp_err));
  endtask

  task automatic release_result(input int hold);
    logic [Size-1:0] r0;
    int changes;
    r0 = res;
    changes = 0;
    res_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (res !== r0 || res_valid !== 1'b1 || din_ready !== 1'b0) changes++;
    end
    if (hold > 0) check_val("bp_stable", AW'(changes), AW'(0));
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check_val("res_valid_drop", AW'(res_valid), AW'(0));
    check_val("idle_din_ready", AW'(din_ready), AW'(1));
    check_val("idle_cnt", AW'(digit_cnt), AW'(0));
  endtask

  task automatic check_reset_outputs();
    check_val("rst_pa_en", AW'(pa_en), AW'(0));
    check_val("rst_pa_a", pa_a, AW'(0));
    check_val("rst_res", AW'(res), AW'(0));
    check_val("rst_res_valid", AW'(res_valid), AW'(0));
    check_val("rst_din_ready", AW'(din_ready), AW'(0));
    check_val("rst_digit_cnt", AW'(digit_cnt), AW'(0));
    check_val("rst_err", AW'(err), AW'(0));
  endtask

  initial begin
    logic [95:0] r;
    logic [Size-1:0] two;
    int n;

    repeat (2) @(negedge clk);
    check_reset_outputs();
    rst_n = 1'b1;
    @(negedge clk);
    check_val("din_ready_after_rst", AW'(din_ready), AW'(1));

    // Single digit, with launch latency.
    pa_log.delete();
    digs[0] = 78'h5;
    send_digit(digs[0], 1'b1);
    check_val("launch_early", AW'(pa_en), AW'(0));
    @(negedge clk);
    check_val("launch_lat", AW'(pa_en), AW'(1));
    check_val("single_pa_a", pa_a, AW'(5));
    check_result(1, 1'b0, 1'b1);
    check_val("single_res", AW'(res), AW'(5));
    release_result(0);

    // Two digits with 20 cycles of result backpressure.
    pa_log.delete();
    digs[0] = 78'h1;
    digs[1] = 78'h2;
    send_digit(digs[0], 1'b0);
    send_digit(digs[1], 1'b1);
    check_result(2, 1'b0, 1'b1);
    two = '0;
    two[RADIX] = 1'b1;
    two[1] = 1'b1;
    check_val("two_digit_res", AW'(res), AW'(two));
    release_result(20);

    // Random operands; first one is the full 10-digit run.
    for (int k = 0; k < 8; k++) begin
      n = (k == 0) ? 10 : int'($urandom_range(1, 10));
      pa_log.delete();
      for (int i = 0; i < n; i++) begin
        r = {$urandom, $urandom, $urandom};
        digs[i] = r[RADIX-1:0];
      end
      for (int i = 0; i < n; i++) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        send_digit(digs[i], i == n - 1);
      end
      check_result(n, 1'b0, 1'b1);
      release_result(int'($urandom_range(0, 5)));
    end

    // Spurious pa_en_out while idle.
    spur_eo = 1'b1;
    @(negedge clk);
    spur_eo = 1'b0;
    check_val("spur_err", AW'(err), AW'(1));
    check_val("spur_din_ready", AW'(din_ready), AW'(1));
    check_val("spur_res_valid", AW'(res_valid), AW'(0));
    check_val("spur_pa_en", AW'(pa_en), AW'(0));

    // Reset in the middle of WAIT, then a fresh operand.
    pa_log.delete();
    send_digit(78'h3, 1'b1);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs();
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    pa_log.delete();
    digs[0] = 78'h7;
    send_digit(digs[0], 1'b1);
    check_result(1, 1'b0, 1'b1);
    check_val("post_rst_res", AW'(res), AW'(7));
    release_result(0);

    // Overflow: one digit past MAX_DIGITS with no last flag.
    pa_log.delete();
    for (int i = 0; i <= MAX_DIGITS; i++) begin
      r = {$urandom, $urandom, $urandom};
      digs[i] = r[RADIX-1:0];
    end
    for (int i = 0; i <= MAX_DIGITS; i++) send_digit(digs[i], 1'b0);
    check_result(MAX_DIGITS, 1'b1, 1'b0);
    release_result(0);

`ifdef PA_WATCHDOG_EN
    // Watchdog: phase_a never answers.
    @(negedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    stub_on = 1'b0;
    pa_log.delete();
    begin
      int t0;
      int t;
      t0 = cyc;
      t = 0;
      send_digit(78'h9, 1'b1);
      while (!res_valid && t < 70000) begin
        @(negedge clk);
        t++;
      end
      check_val("wd_res_valid", AW'(res_valid), AW'(1));
      check_val("wd_err", AW'(err), AW'(1));
      check_val("wd_res", AW'(res), AW'(0));
      check_val("wd_elapsed", AW'((cyc - t0) >= 65535), AW'(1));
    end
    release_result(0);
    stub_on = 1'b1;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
